lift_ram_seq: RTL
=================

Name: lift_ram_seq

Overview:
- Initiator/sequencer that drives the three pixel RAM ports (left-even, right-even, odd) used by the lifting stage of the JPEG-2000 5/3 DWT.
- For each index in a row it reads the left, right and odd samples, computes one integer lifting step and writes the result back through the odd port.
- Sits between the row/column control FSM and the pixel RAM block, which is a synchronous responder with 1-cycle read latency.

Parameters:
- DW, 26, pixel data width (signed two's complement)
- AW, 7, RAM address width (128 entries)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to process a row; sampled only in IDLE
- mode  in  1  0 = predict step, 1 = update step; latched on accepted start
- len  in  AW+1  number of indices to process (0..128); latched on accepted start
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse when the row is complete
- pix_addr_l  out  AW  left-even RAM read address
- pix_addr_r  out  AW  right-even RAM read address
- pix_addr_odd  out  AW  odd RAM read/write address
- pix_we_odd  out  1  odd RAM write enable
- pix_din_odd  out  DW  odd RAM write data
- pix_dout_l  in  DW  left-even RAM read data, valid 1 cycle after address
- pix_dout_r  in  DW  right-even RAM read data, valid 1 cycle after address
- pix_dout_odd  in  DW  odd RAM read data, valid 1 cycle after address

Behaviour:
- Reset (async, rst_n=0): state IDLE, idx=0. All addresses 0, pix_we_odd=0, pix_din_odd=0, busy=0, done=0. Takes effect immediately, including mid-row. No partial write is issued after reset asserts.
- All outputs are registered.
- FSM states: IDLE, RD, CALC, WR, DONE.
- IDLE:
  - start=1 and len>0: latch mode and len, idx=0, go to RD.
  - start=1 and len=0: go to DONE with no RAM access.
  - start=0: stay in IDLE.
- RD: pix_addr_l = pix_addr_r = pix_addr_odd = idx; pix_we_odd=0. Go to CALC.
- CALC: RAM data is valid this cycle.
  - Sign-extend operands to DW+1 bits and compute s = l + r.
  - predict (mode 0): res = odd − (s >>> 1).
  - update (mode 1): res = odd + ((s + 2) >>> 2).
  - Shifts are arithmetic (floor). res is truncated to DW bits, so overflow wraps with no saturation.
  - Register res and go to WR.
- WR: pix_addr_odd=idx, pix_din_odd=res, pix_we_odd=1 for exactly this cycle.
  - idx == len−1: go to DONE.
  - Otherwise: idx+1, go to RD.
- DONE: done=1 for one cycle, busy still 1. Go to IDLE. busy falls the following cycle.
- Throughput: 3 cycles per index. Row of n>0 takes 3n+1 cycles from the first RD to the end of DONE. len=0 takes 1 cycle (DONE only).
- start asserted while busy is ignored and not queued. mode and len changes while busy have no effect.
- pix_we_odd is never high outside WR.
- Addresses hold their last value outside RD/WR.
- len > 128 cannot occur with AW=7. len=128 processes indices 0..127 without wrap.

Test Plan:
- Predict, len=1, RAM l[0]=10, r[0]=20, odd[0]=100 -> one write with odd[0]=85. Write pulse on cycle 3 after start. done on cycle 4. busy high for 4 cycles.
- Update with negatives, len=1, l=−7, r=−4, odd=50 -> (−9)>>>2 = −3, writes 47. Predict with l=−3, r=0, odd=0 -> writes 2 (floor rounding).
- Wrap: predict, odd=−2^25, l=r=2 -> writes 33554430 (0x1FFFFFE), no saturation.
- Full row: len=128, predict, l[i]=i, r[i]=i+2, odd[i]=0 -> odd[i] = −(i+1) for all i. Exactly 128 write pulses, addresses 0..127 in order. done 385 cycles after the first RD.
- len=0 -> done pulse the cycle after start, no RAM write. start pulses during a busy row -> ignored, exactly one done per accepted start.
- rst_n low in the CALC cycle of index 5 of a 10-index row -> outputs reset immediately, no write to index 5. A fresh start afterwards processes from index 0.

Source files
------------

// File: rtl/lift_ram_seq.sv
// lift_ram_seq: drives the left/right/odd pixel RAM ports for one 5/3 lifting
// step per index (read, compute, write back to odd), 3 cycles per index.
`default_nettype none

module lift_ram_seq #(
  parameter int DW = 26,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pix_addr_l,
  output logic [AW-1:0] pix_addr_r,
  output logic [AW-1:0] pix_addr_odd,
  output logic          pix_we_odd,
  output logic [DW-1:0] pix_din_odd,
  input  logic [DW-1:0] pix_dout_l,
  input  logic [DW-1:0] pix_dout_r,
  input  logic [DW-1:0] pix_dout_odd
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CALC = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic signed [DW+1:0] c_two = (DW+2)'(2);

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_idx;
  logic [AW:0]     r_len;
  logic            r_mode;
  logic            r_busy;
  logic            r_done;
  logic            r_we;
  logic [DW-1:0]   r_din;
  logic [AW-1:0]   r_addr;
  logic            w_last;

  // Two guard bits: l+r needs one, and the +2 rounding term of the update
  // step can carry into a second.
  logic signed [DW+1:0] w_l;
  logic signed [DW+1:0] w_r;
  logic signed [DW+1:0] w_o;
  logic signed [DW+1:0] w_s;
  logic        [DW-1:0] w_res;

  assign w_l    = {{2{pix_dout_l[DW-1]}},   pix_dout_l};
  assign w_r    = {{2{pix_dout_r[DW-1]}},   pix_dout_r};
  assign w_o    = {{2{pix_dout_odd[DW-1]}}, pix_dout_odd};
  assign w_s    = w_l + w_r;
  assign w_res  = r_mode ? DW'(w_o + ((w_s + c_two) >>> 2))
                         : DW'(w_o - (w_s >>> 1));
  assign w_last = ({1'b0, r_idx} == (r_len - 1'b1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (len != '0) ? S_RD : S_DONE;
      end
      S_RD:    w_next = S_CALC;
      S_CALC:  w_next = S_WR;
      S_WR:    w_next = w_last ? S_DONE : S_RD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_din   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
      r_we    <= (w_next == S_WR);
      case (r_state)
        S_IDLE: begin
          if (start && (len != '0)) begin
            r_mode <= mode;
            r_len  <= len;
            r_idx  <= '0;
            r_addr <= '0;
          end
        end
        S_CALC: r_din <= w_res;
        S_WR: begin
          if (!w_last) begin
            r_idx  <= r_idx + 1'b1;
            r_addr <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign pix_addr_l   = r_addr;
  assign pix_addr_r   = r_addr;
  assign pix_addr_odd = r_addr;
  assign pix_we_odd   = r_we;
  assign pix_din_odd  = r_din;

endmodule

`default_nettype wire
